score_tracker: RTL and testbench
================================

# score_tracker

Game-rule stage directly upstream of the per-digit score displays. Watches the pipe scroll strobe, pipe occupancy of the bird column and the collision flag, and decides when the bird has cleared a pipe. Emits one-cycle increment pulses for the ones and tens display digits, plus a clear pulse at game start. Also keeps a BCD copy of the score and the game-phase flags.

## Interface
- MAX_SCORE, 99, saturation value for the score (legal range 1..99); no pulses are issued once it is reached.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clock clk.
- start  in  1  level; begins a game from IDLE or OVER.
- tick  in  1  one-cycle strobe; pipes shift one column on this cycle.
- pipe_at_bird  in  1  level, sampled on tick; high while a pipe column overlaps the bird column.
- collision  in  1  level; bird touches a pipe or the ground.
- up_ones  out  1  one-cycle increment pulse for the ones digit.
- up_tens  out  1  one-cycle increment pulse for the tens digit.
- clear_digits  out  1  one-cycle pulse at game start; ORed into the digit displays' reset.
- score_bcd  out  8  {tens[7:4], ones[3:0]}, each 0..9.
- playing  out  1  high in PLAY and IN_PIPE.
- game_over  out  1  high in OVER.

## Operation
- States: IDLE, PLAY, IN_PIPE, OVER.
- IDLE:
  - start → PLAY; clear_digits pulses; score_bcd ← 0x00.
- PLAY:
  - collision → OVER (highest priority).
  - Else tick && pipe_at_bird → IN_PIPE.
- IN_PIPE:
  - collision → OVER; no point.
  - Else tick && !pipe_at_bird → PLAY and award one point.
  - tick with pipe_at_bird still high keeps the state (wide pipes).
- OVER:
  - Outputs hold the final score.
  - start → PLAY with clear_digits pulse and score_bcd ← 0x00.
- start is ignored in PLAY and IN_PIPE. Holding start through OVER→PLAY does not re-clear the score.
- Point award:
  - If score < MAX_SCORE: up_ones = 1, and ones increments.
  - If ones was 9: ones ← 0, tens increments, and up_tens = 1 in the same cycle as up_ones.
- Saturation: at score == MAX_SCORE (compared in decimal), awards produce no pulses and no score change; the FSM still runs normally.
- Pulses are exactly one cycle wide. The downstream digit advances on every cycle its increment input is high, so pulses are never stretched and never issued on consecutive cycles.
- A collision has no effect in IDLE or OVER.

## Timing
- All outputs are registered.
- Reset: state IDLE, up_ones = up_tens = clear_digits = 0, score_bcd = 0x00, playing = 0, game_over = 0.
- Award latency:
  - The qualifying tick is sampled at edge N.
  - up_ones/up_tens are high during cycle N+1 only.
  - score_bcd shows the new value from N+1.
  - playing stays high throughout.
- clear_digits is high for the one cycle after the start edge. playing rises in that same cycle.
- game_over rises the cycle after collision is sampled.
- Simultaneous collision and exit tick in IN_PIPE: collision wins; no pulse, no score change.
- Reset mid-game overrides everything: the next cycle is IDLE, any pending pulse is dropped, and score = 0.
- Minimum spacing between awards is two ticks, so up_ones is never high on consecutive cycles.

## Test plan
- Reset then idle: reset high 2 cycles, random tick and pipe_at_bird → all outputs 0, state IDLE; clear_digits only after start.
- Single pass: start; tick with pipe_at_bird=1; tick with pipe_at_bird=0 → up_ones high exactly 1 cycle, up_tens=0, score_bcd=0x01.
- Tens carry: drive 10 passes → on the 10th, up_ones and up_tens are high in the same cycle and score_bcd=0x10.
- Collision in pipe: score 0x03; enter pipe; collision asserted on the same cycle as the exit tick → no pulse, game_over=1, score_bcd stays 0x03. Then start → clear_digits pulse, score_bcd=0x00, playing=1.
- Saturation: MAX_SCORE=12; drive 15 passes → exactly 12 up_ones pulses, 1 up_tens pulse, score_bcd=0x12.
- Reset mid-award: assert reset on the cycle after the exit tick → no up_ones in the following cycles, score_bcd=0x00, state IDLE.

Source files
------------

// File: rtl/score_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : score_tracker_if
// Description : Game-rule signal bundle between the playfield logic and the
//               score tracker (inputs from the game, pulses to the digits).
// Revision    : 1.0 - initial release
// ============================================================================
interface score_tracker_if;
  // Game-side inputs
  logic       start;
  logic       tick;
  logic       pipe_at_bird;
  logic       collision;
  // Score-side outputs
  logic       up_ones;
  logic       up_tens;
  logic       clear_digits;
  logic [7:0] score_bcd;
  logic       playing;
  logic       game_over;

  // The game logic drives events and observes the score.
  modport master (
    output start, tick, pipe_at_bird, collision,
    input  up_ones, up_tens, clear_digits, score_bcd, playing, game_over
  );

  // The score tracker consumes events and produces the score outputs.
  modport slave (
    input  start, tick, pipe_at_bird, collision,
    output up_ones, up_tens, clear_digits, score_bcd, playing, game_over
  );
endinterface
`default_nettype wire

// File: rtl/score_tracker.sv
`default_nettype none
// ============================================================================
// Module      : score_tracker
// Description : Decides when the bird has cleared a pipe, issues one-cycle
//               increment pulses for the ones/tens digits, a clear pulse at
//               game start, and keeps a saturating BCD copy of the score.
// Revision    : 1.0 - initial release
// ============================================================================
module score_tracker #(
  parameter int MAX_SCORE = 99
) (
  input  wire logic       clk,
  input  wire logic       reset,
  score_tracker_if.slave  bus
);

  // Saturation limit split into decimal digits so it compares against BCD.
  localparam logic [3:0] c_MAX_TENS = 4'(MAX_SCORE / 10);
  localparam logic [3:0] c_MAX_ONES = 4'(MAX_SCORE % 10);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAY    = 2'd1,
    S_IN_PIPE = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       up_ones_q, up_ones_d;
  logic       up_tens_q, up_tens_d;
  logic       clear_q, clear_d;
  logic       playing_q, playing_d;
  logic       game_over_q, game_over_d;
  logic       w_at_max;

  // Score has reached the ceiling (decimal comparison of the BCD digits).
  assign w_at_max = (tens_q > c_MAX_TENS) ||
                    ((tens_q == c_MAX_TENS) && (ones_q >= c_MAX_ONES));

  // Next-state, score update and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    up_ones_d = 1'b0;
    up_tens_d = 1'b0;
    clear_d   = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        // Collisions are meaningless outside a game; only start matters.
        if (bus.start) begin
          state_d = S_PLAY;
          clear_d = 1'b1;
          ones_d  = 4'd0;
          tens_d  = 4'd0;
        end
      end
      S_PLAY: begin
        if (bus.collision) begin
          state_d = S_OVER;
        end else if (bus.tick && bus.pipe_at_bird) begin
          state_d = S_IN_PIPE;
        end
      end
      S_IN_PIPE: begin
        // Collision beats an exit tick in the same cycle: no point awarded.
        if (bus.collision) begin
          state_d = S_OVER;
        end else if (bus.tick && !bus.pipe_at_bird) begin
          state_d = S_PLAY;
          if (!w_at_max) begin
            up_ones_d = 1'b1;
            if (ones_q == 4'd9) begin
              ones_d    = 4'd0;
              tens_d    = tens_q + 4'd1;
              up_tens_d = 1'b1;
            end else begin
              ones_d = ones_q + 4'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    playing_d   = (state_d == S_PLAY) || (state_d == S_IN_PIPE);
    game_over_d = (state_d == S_OVER);
  end

  // State, score and output registers; reset drops any pending pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ones_q      <= 4'd0;
      tens_q      <= 4'd0;
      up_ones_q   <= 1'b0;
      up_tens_q   <= 1'b0;
      clear_q     <= 1'b0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      up_ones_q   <= up_ones_d;
      up_tens_q   <= up_tens_d;
      clear_q     <= clear_d;
      playing_q   <= playing_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.up_ones      = up_ones_q;
  assign bus.up_tens      = up_tens_q;
  assign bus.clear_digits = clear_q;
  assign bus.score_bcd    = {tens_q, ones_q};
  assign bus.playing      = playing_q;
  assign bus.game_over    = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_score_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_tracker
// Description : Scoreboard bench for score_tracker. Two instances (ceilings
//               99 and 12) receive identical game stimulus; each award the
//               stimulus issues pushes the expected pulse/score, and a
//               per-instance monitor pops and compares on every up_ones.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_tracker;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  score_tracker_if bus99 ();
  score_tracker_if bus12 ();

  score_tracker #(.MAX_SCORE(99)) dut99 (.clk(clk), .reset(reset), .bus(bus99));
  score_tracker #(.MAX_SCORE(12)) dut12 (.clk(clk), .reset(reset), .bus(bus12));

  int tests = 0;
  int fails = 0;

  // Reference scores and pending expectations {up_tens, score_bcd}.
  int         sc99 = 0;
  int         sc12 = 0;
  logic [8:0] q99[$];
  logic [8:0] q12[$];
  logic [8:0] e99, e12;
  logic       prev99 = 1'b0;
  logic       prev12 = 1'b0;
  int         n_ones12 = 0;
  int         n_tens12 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int s);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(s / 10);
    o = 4'(s % 10);
    return {t, o};
  endfunction

  task automatic drive(input logic s, input logic t, input logic p, input logic c);
    bus99.start = s; bus99.tick = t; bus99.pipe_at_bird = p; bus99.collision = c;
    bus12.start = s; bus12.tick = t; bus12.pipe_at_bird = p; bus12.collision = c;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Record the point the next exit tick should award on each instance.
  task automatic expect_award();
    if (sc99 < 99) begin
      sc99++;
      q99.push_back({(sc99 % 10 == 0), bcd(sc99)});
    end
    if (sc12 < 12) begin
      sc12++;
      q12.push_back({(sc12 % 10 == 0), bcd(sc12)});
    end
  endtask

  task automatic pass_pipe();
    drive(1'b0, 1'b1, 1'b1, 1'b0); cyc();
    drive(1'b0, 1'b0, 1'b1, 1'b0); cyc();
    expect_award();
    drive(1'b0, 1'b1, 1'b0, 1'b0); cyc();
    drive(1'b0, 1'b0, 1'b0, 1'b0); cyc();
  endtask

  task automatic check_both(input string name, input logic [7:0] s99, input logic [7:0] s12,
                            input logic pl, input logic go);
    check({name, "_d99_score"},   bus99.score_bcd, s99);
    check({name, "_d12_score"},   bus12.score_bcd, s12);
    check({name, "_d99_playing"}, bus99.playing,   pl);
    check({name, "_d12_playing"}, bus12.playing,   pl);
    check({name, "_d99_over"},    bus99.game_over, go);
    check({name, "_d12_over"},    bus12.game_over, go);
  endtask

  // Monitor for the 99-ceiling instance: every up_ones consumes one expectation.
  always @(negedge clk) begin
    if (bus99.up_ones === 1'b1) begin
      check("d99_no_consecutive", prev99, 1'b0);
      if (q99.size() == 0) begin
        tests++; fails++;
        $display("FAIL d99_unexpected_pulse: got up_ones=1 score %0h, expected no pulse", bus99.score_bcd);
      end else begin
        e99 = q99.pop_front();
        check("d99_up_tens", bus99.up_tens, e99[8]);
        check("d99_award_score", bus99.score_bcd, e99[7:0]);
      end
    end else if (bus99.up_tens === 1'b1) begin
      check("d99_tens_without_ones", bus99.up_tens, 1'b0);
    end
    prev99 = (bus99.up_ones === 1'b1);
  end

  // Monitor for the 12-ceiling instance; also counts pulses for the saturation test.
  always @(negedge clk) begin
    if (bus12.up_ones === 1'b1) begin
      n_ones12++;
      if (bus12.up_tens === 1'b1) n_tens12++;
      check("d12_no_consecutive", prev12, 1'b0);
      if (q12.size() == 0) begin
        tests++; fails++;
        $display("FAIL d12_unexpected_pulse: got up_ones=1 score %0h, expected no pulse", bus12.score_bcd);
      end else begin
        e12 = q12.pop_front();
        check("d12_up_tens", bus12.up_tens, e12[8]);
        check("d12_award_score", bus12.score_bcd, e12[7:0]);
      end
    end else if (bus12.up_tens === 1'b1) begin
      check("d12_tens_without_ones", bus12.up_tens, 1'b0);
    end
    prev12 = (bus12.up_ones === 1'b1);
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset with random game activity.
    repeat (2) begin
      drive(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0);
      cyc();
    end
    check_both("reset", 8'h00, 8'h00, 1'b0, 1'b0);
    check("reset_clear", bus99.clear_digits, 1'b0);
    check("reset_up_ones", bus99.up_ones, 1'b0);
    reset = 1'b0;

    // Idle: ticks, pipes and collisions do nothing without start.
    repeat (4) begin
      drive(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      cyc();
      check("idle_clear", bus99.clear_digits, 1'b0);
      check("idle_playing", bus99.playing, 1'b0);
    end
    check_both("idle", 8'h00, 8'h00, 1'b0, 1'b0);

    // Start a game.
    drive(1'b1, 1'b0, 1'b0, 1'b0); cyc();
    check("start_clear", bus99.clear_digits, 1'b1);
    check_both("start", 8'h00, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0); cyc();
    check("start_clear_one_cycle", bus99.clear_digits, 1'b0);

    // Single pass.
    pass_pipe();
    check_both("pass1", 8'h01, 8'h01, 1'b1, 1'b0);

    // Tens carry on the 10th pass.
    repeat (9) pass_pipe();
    check_both("pass10", 8'h10, 8'h10, 1'b1, 1'b0);

    // Five more: 12-ceiling instance saturates.
    repeat (5) pass_pipe();
    check_both("pass15", 8'h15, 8'h12, 1'b1, 1'b0);
    check("sat_ones_pulses", n_ones12, 12);
    check("sat_tens_pulses", n_tens12, 1);

    // Collision while flying: game over, score held; collisions in OVER are ignored.
    drive(1'b0, 1'b0, 1'b0, 1'b1); cyc();
    check_both("collide_play", 8'h15, 8'h12, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1); cyc();
    drive(1'b0, 1'b0, 1'b0, 1'b0); cyc();
    check_both("over_hold", 8'h15, 8'h12, 1'b0, 1'b1);

    // Restart, holding start for several cycles: only one clear.
    drive(1'b1, 1'b0, 1'b0, 1'b0); cyc();
    sc99 = 0; sc12 = 0;
    check("restart_clear", bus12.clear_digits, 1'b1);
    check_both("restart", 8'h00, 8'h00, 1'b1, 1'b0);
    repeat (3) begin
      cyc();
      check("held_start_no_clear", bus99.clear_digits, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0); cyc();

    // Collision coincident with the exit tick.
    repeat (3) pass_pipe();
    check_both("pre_collide", 8'h03, 8'h03, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0); cyc();
    drive(1'b0, 1'b0, 1'b1, 1'b0); cyc();
    drive(1'b0, 1'b1, 1'b0, 1'b1); cyc();
    check("collide_exit_no_pulse", bus99.up_ones, 1'b0);
    check_both("collide_exit", 8'h03, 8'h03, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0); cyc();
    drive(1'b1, 1'b0, 1'b0, 1'b0); cyc();
    sc99 = 0; sc12 = 0;
    check("collide_restart_clear", bus99.clear_digits, 1'b1);
    check_both("collide_restart", 8'h00, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0); cyc();

    // Wide pipe then reset right after the exit tick.
    pass_pipe();
    drive(1'b0, 1'b1, 1'b1, 1'b0); cyc();
    drive(1'b0, 1'b1, 1'b1, 1'b0); cyc();
    check("wide_pipe_no_pulse", bus99.up_ones, 1'b0);
    check_both("wide_pipe", 8'h01, 8'h01, 1'b1, 1'b0);
    expect_award();
    drive(1'b0, 1'b1, 1'b0, 1'b0); cyc();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      cyc();
      check("reset_mid_up_ones", bus99.up_ones, 1'b0);
      check_both("reset_mid", 8'h00, 8'h00, 1'b0, 1'b0);
    end
    reset = 1'b0;
    sc99 = 0; sc12 = 0;
    repeat (2) cyc();

    check("d99_queue_drained", q99.size(), 0);
    check("d12_queue_drained", q12.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
